i2s_sample_scheduler: RTL and testbench

- Paces audio samples into the I2S transmitter.
- Accepts stereo samples from the audio core at an irregular, bursty rate and buffers them in a small FIFO.
- Emits exactly one APDATA_VALID strobe every MCLK_FRAME_DIVIDER AMCLK cycles, carrying left/right data to the transmitter.
- Handles start-up priming, underrun (repeat last sample, then mute and re-prime) and overrun (drop incoming), and reports sticky status to the control CPU.

---
 rtl/i2s_sample_scheduler_pkg.sv | 34 +++
 rtl/i2s_sample_fifo.sv | 62 ++++++
 rtl/i2s_sample_scheduler.sv | 154 +++++++++++++++
 tb/tb_i2s_sample_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_sample_scheduler_pkg.sv
// Shared types and width helpers for the I2S sample scheduler and its FIFO.
// Pure declarations: no latency, no flow control.
package i2s_sample_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_e;

  localparam int DEF_DATA_BITS      = 24;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_FRAME_DIV      = 256;
  localparam int DEF_FILL_TARGET    = 4;
  localparam int DEF_UNDERRUN_LIMIT = 3;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Level counts 0..depth inclusive, so it needs one bit more than the pointers.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int tick_width(input int div);
    return clog2_min1(div);
  endfunction

  function automatic int empty_cnt_width(input int limit);
    return clog2_min1(limit + 1);
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous stereo-sample FIFO with flush; head word is presented from flop storage.
// Level updates one cycle after push/pop; a full FIFO accepts a push only alongside a pop.
module i2s_sample_fifo
  import i2s_sample_scheduler_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign pop_ok   = pop_vld && !empty && !flush;
  assign push_ok  = push_vld && !flush && (!full || pop_ok);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Paces buffered stereo samples into the I2S transmitter, one strobe per frame period.
// Output registered on the tick edge; source is never stalled -- overflow drops and flags overrun.
module i2s_sample_scheduler
  import i2s_sample_scheduler_pkg::*;
#(
  parameter int I2S_DATA_BITS      = DEF_DATA_BITS,
  parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH,
  parameter int MCLK_FRAME_DIVIDER = DEF_FRAME_DIV,
  parameter int FILL_TARGET        = DEF_FILL_TARGET,
  parameter int UNDERRUN_LIMIT     = DEF_UNDERRUN_LIMIT
) (
  input  logic                          AMCLK_i,
  input  logic                          reset,
  input  logic                          enable_i,
  input  logic                          clr_status_i,
  input  logic [I2S_DATA_BITS-1:0]      SRC_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0]      SRC_RIGHT_i,
  input  logic                          SRC_VALID_i,
  output logic [I2S_DATA_BITS-1:0]      APSDATA_LEFT_o,
  output logic [I2S_DATA_BITS-1:0]      APSDATA_RIGHT_o,
  output logic                          APDATA_VALID_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          running_o,
  output logic                          underrun_o,
  output logic                          overrun_o
);

  localparam int DW     = 2 * I2S_DATA_BITS;
  localparam int LVL_W  = level_width(FIFO_DEPTH);
  localparam int TICK_W = tick_width(MCLK_FRAME_DIVIDER);
  localparam int EC_W   = empty_cnt_width(UNDERRUN_LIMIT);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MCLK_FRAME_DIVIDER - 1);
  localparam logic [LVL_W-1:0]  FILL_LVL  = LVL_W'(FILL_TARGET);
  localparam logic [EC_W-1:0]   EC_LAST   = EC_W'(UNDERRUN_LIMIT - 1);

  sched_state_e      state_q;
  sched_state_e      state_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [EC_W-1:0]   empty_cnt_q;

  logic              active;
  logic              tick;
  logic              push_vld;
  logic              pop_vld;
  logic              run_tick;
  logic              mute_vld;
  logic              underrun_set;
  logic              overrun_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [DW-1:0]     push_dat;
  logic [DW-1:0]     head_dat;

  // Dropping enable takes effect combinationally so the same edge flushes and idles.
  assign active       = enable_i && (state_q != ST_IDLE);
  assign tick         = active && (tick_cnt_q == TICK_LAST);
  assign push_vld     = active && SRC_VALID_i;
  assign push_dat     = {SRC_LEFT_i, SRC_RIGHT_i};
  assign underrun_set = run_tick && fifo_empty;
  assign overrun_set  = push_vld && fifo_full && !pop_vld;
  assign fifo_level_o = fifo_level;

  i2s_sample_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (AMCLK_i),
    .rst      (reset),
    .flush    (!active),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge AMCLK_i or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (tick && (fifo_level >= FILL_LVL)) state_d = ST_RUN;
        ST_RUN:   if (mute_vld) state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running_o = (state_q == ST_RUN);
    run_tick  = tick && (state_q == ST_RUN);
    pop_vld   = run_tick && !fifo_empty;
    mute_vld  = run_tick && fifo_empty && (empty_cnt_q == EC_LAST);
  end

  always_ff @(posedge AMCLK_i or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      empty_cnt_q <= '0;
    end else if (!active) begin
      tick_cnt_q  <= '0;
      empty_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
      if (run_tick) begin
        if (!fifo_empty || mute_vld) empty_cnt_q <= '0;
        else                         empty_cnt_q <= empty_cnt_q + EC_W'(1);
      end
    end
  end

  // An empty tick short of the limit leaves the data registers alone, repeating the last sample.
  always_ff @(posedge AMCLK_i or posedge reset) begin
    if (reset) begin
      APDATA_VALID_o  <= 1'b0;
      APSDATA_LEFT_o  <= '0;
      APSDATA_RIGHT_o <= '0;
    end else if (!active) begin
      APDATA_VALID_o  <= 1'b0;
      APSDATA_LEFT_o  <= '0;
      APSDATA_RIGHT_o <= '0;
    end else begin
      APDATA_VALID_o <= run_tick;
      if (pop_vld) begin
        {APSDATA_LEFT_o, APSDATA_RIGHT_o} <= head_dat;
      end else if (mute_vld) begin
        APSDATA_LEFT_o  <= '0;
        APSDATA_RIGHT_o <= '0;
      end
    end
  end

  always_ff @(posedge AMCLK_i or posedge reset) begin
    if (reset) begin
      underrun_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      underrun_o <= underrun_set || (underrun_o && !clr_status_i);
      overrun_o  <= overrun_set  || (overrun_o  && !clr_status_i);
    end
  end

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Scenario bench for i2s_sample_scheduler: queue of accepted samples checked against each strobe.
module tb_i2s_sample_scheduler;

  localparam int W   = 24;
  localparam int DW  = 2 * W;
  localparam int DIV = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clr;
  logic [W-1:0]  src_l;
  logic [W-1:0]  src_r;
  logic          src_v;
  logic [W-1:0]  out_l;
  logic [W-1:0]  out_r;
  logic          out_v;
  logic [3:0]    level;
  logic          running;
  logic          underrun;
  logic          overrun;

  int            cyc_n = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];

  i2s_sample_scheduler dut (
    .AMCLK_i         (clk),
    .reset           (rst),
    .enable_i        (enable),
    .clr_status_i    (clr),
    .SRC_LEFT_i      (src_l),
    .SRC_RIGHT_i     (src_r),
    .SRC_VALID_i     (src_v),
    .APSDATA_LEFT_o  (out_l),
    .APSDATA_RIGHT_o (out_r),
    .APDATA_VALID_o  (out_v),
    .fifo_level_o    (level),
    .running_o       (running),
    .underrun_o      (underrun),
    .overrun_o       (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [DW-1:0] mk(input int k);
    logic [W-1:0] l;
    logic [W-1:0] r;
    l = W'(k);
    r = W'(32'h00A0_0000 + k);
    return {l, r};
  endfunction

  function automatic logic [DW-1:0] pop_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic push(input int k, input bit acc);
    {src_l, src_r} = mk(k);
    src_v = 1'b1;
    cyc();
    src_v = 1'b0;
    if (acc) exp_q.push_back(mk(k));
  endtask

  task automatic wait_strobe(input int max, output bit found, output int at);
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < max && !found; i++) begin
      cyc();
      if (out_v === 1'b1) begin
        found = 1'b1;
        at    = cyc_n;
      end
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    clr    = 1'b0;
    src_v  = 1'b0;
    src_l  = '0;
    src_r  = '0;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clr = 1'b0; src_v = 1'b0; src_l = '0; src_r = '0;
    #1;
    n_vec++;
    if ({out_v, running, underrun, overrun, out_l, out_r} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b run=%b ur=%b or=%b l=%h r=%h want all 0",
               out_v, running, underrun, overrun, out_l, out_r);
    end
    n_vec++;
    if (level !== 4'd0) begin
      n_err++;
      $display("FAIL reset_level got %0d want 0", level);
    end
    do_reset();
  endtask

  task automatic test_prime_steady();
    bit            f;
    int            t0, at, prev;
    logic [DW-1:0] e;
    do_reset();
    enable = 1'b1;
    cyc();
    t0 = cyc_n;
    for (int k = 1; k <= 4; k++) push(k, 1'b1);
    n_vec++;
    if (level !== 4'd4 || running !== 1'b0) begin
      n_err++;
      $display("FAIL prime_level got lvl=%0d run=%b want lvl=4 run=0", level, running);
    end
    wait_strobe(700, f, at);
    e = pop_exp();
    n_vec++;
    if (!f) begin
      n_err++;
      $display("FAIL first_strobe timeout after 700 cycles");
    end else if (at - t0 != 2 * DIV || {out_l, out_r} !== e) begin
      n_err++;
      $display("FAIL first_strobe got delay=%0d data=%h want delay=%0d data=%h",
               at - t0, {out_l, out_r}, 2 * DIV, e);
    end
    for (int k = 5; k <= 8; k++) begin
      push(k, 1'b1);
      prev = at;
      wait_strobe(300, f, at);
      e = pop_exp();
      n_vec++;
      if (!f || at - prev != DIV || {out_l, out_r} !== e || underrun !== 1'b0 || overrun !== 1'b0) begin
        n_err++;
        $display("FAIL steady_%0d got found=%b gap=%0d data=%h ur=%b or=%b want gap=%0d data=%h flags 0",
                 k, f, at - prev, {out_l, out_r}, underrun, overrun, DIV, e);
      end
    end
  endtask

  // Continues from the steady state left by test_prime_steady: samples 6..8 queued.
  task automatic test_underrun();
    bit            f;
    int            at;
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) begin
      wait_strobe(300, f, at);
      e = pop_exp();
      n_vec++;
      if (!f || {out_l, out_r} !== e) begin
        n_err++;
        $display("FAIL drain_%0d got found=%b data=%h want %h", i, f, {out_l, out_r}, e);
      end
    end
    n_vec++;
    if (level !== 4'(exp_q.size())) begin
      n_err++;
      $display("FAIL drain_level got %0d want %0d", level, exp_q.size());
    end
    wait_strobe(300, f, at);
    e = pop_exp();
    n_vec++;
    if (!f || {out_l, out_r} !== e || underrun !== 1'b0) begin
      n_err++;
      $display("FAIL last_entry got found=%b data=%h ur=%b want data=%h ur=0", f, {out_l, out_r}, underrun, e);
    end
    for (int i = 0; i < 2; i++) begin
      wait_strobe(300, f, at);
      n_vec++;
      if (!f || {out_l, out_r} !== mk(8) || underrun !== 1'b1 || running !== 1'b1) begin
        n_err++;
        $display("FAIL repeat_%0d got found=%b data=%h ur=%b run=%b want data=%h ur=1 run=1",
                 i, f, {out_l, out_r}, underrun, running, mk(8));
      end
    end
    wait_strobe(300, f, at);
    n_vec++;
    if (!f || {out_l, out_r} !== '0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL mute got found=%b data=%h run=%b want data=0 run=0", f, {out_l, out_r}, running);
    end
    for (int k = 11; k <= 14; k++) push(k, 1'b1);
    wait_strobe(800, f, at);
    e = pop_exp();
    n_vec++;
    if (!f || {out_l, out_r} !== e || running !== 1'b1) begin
      n_err++;
      $display("FAIL reprime got found=%b data=%h run=%b want data=%h run=1", f, {out_l, out_r}, running, e);
    end
  endtask

  task automatic test_overrun();
    bit            f;
    int            at;
    logic [DW-1:0] e;
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 10; k++) push(k, k <= 8);
    n_vec++;
    if (level !== 4'd8 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_flag got lvl=%0d or=%b want lvl=8 or=1", level, overrun);
    end
    for (int i = 0; i < 8; i++) begin
      wait_strobe((i == 0) ? 800 : 300, f, at);
      e = pop_exp();
      n_vec++;
      if (!f || {out_l, out_r} !== e) begin
        n_err++;
        $display("FAIL overrun_out_%0d got found=%b data=%h want %h", i, f, {out_l, out_r}, e);
      end
    end
    wait_strobe(300, f, at);
    n_vec++;
    if (!f || {out_l, out_r} !== mk(8) || underrun !== 1'b1) begin
      n_err++;
      $display("FAIL dropped_never_out got found=%b data=%h ur=%b want data=%h ur=1",
               f, {out_l, out_r}, underrun, mk(8));
    end
  endtask

  task automatic test_full_push_pop();
    bit            f;
    logic [DW-1:0] e;
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 8; k++) push(k, 1'b1);
    f = 1'b0;
    for (int i = 0; i < 600 && !f; i++) begin
      cyc();
      f = (running === 1'b1);
    end
    n_vec++;
    if (!f) begin
      n_err++;
      $display("FAIL enter_run timeout after 600 cycles");
    end
    idle(DIV - 1);
    e = pop_exp();
    push(9, 1'b1);
    n_vec++;
    if (out_v !== 1'b1 || {out_l, out_r} !== e || level !== 4'd8 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL full_push_pop got v=%b data=%h lvl=%0d or=%b want v=1 data=%h lvl=8 or=0",
               out_v, {out_l, out_r}, level, overrun, e);
    end
    n_vec++;
    if (level !== 4'(exp_q.size())) begin
      n_err++;
      $display("FAIL full_model_level got %0d want %0d", level, exp_q.size());
    end
  endtask

  task automatic test_disable_reset();
    bit f;
    int at;
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) push(k, 1'b1);
    wait_strobe(800, f, at);
    enable = 1'b0;
    cyc();
    exp_q.delete();
    n_vec++;
    if (!f || {out_v, running, out_l, out_r} !== '0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL disable got found=%b v=%b run=%b l=%h r=%h lvl=%0d want all 0",
               f, out_v, running, out_l, out_r, level);
    end
    enable = 1'b1;
    cyc();
    for (int k = 21; k <= 24; k++) push(k, 1'b1);
    wait_strobe(800, f, at);
    n_vec++;
    if (!f || out_v !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_before_reset got found=%b v=%b want v=1", f, out_v);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({out_v, running, out_l, out_r} !== '0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset got v=%b run=%b l=%h r=%h lvl=%0d want all 0",
               out_v, running, out_l, out_r, level);
    end
    cyc();
    rst    = 1'b0;
    enable = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_clr_status();
    bit            f;
    int            at;
    logic [DW-1:0] e;
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) push(k, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_strobe((i == 0) ? 800 : 300, f, at);
      e = pop_exp();
      n_vec++;
      if (!f || {out_l, out_r} !== e) begin
        n_err++;
        $display("FAIL clr_drain_%0d got found=%b data=%h want %h", i, f, {out_l, out_r}, e);
      end
    end
    idle(DIV - 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_vec++;
    if (out_v !== 1'b1 || underrun !== 1'b1 || {out_l, out_r} !== mk(4)) begin
      n_err++;
      $display("FAIL clr_same_cycle got v=%b ur=%b data=%h want v=1 ur=1 data=%h",
               out_v, underrun, {out_l, out_r}, mk(4));
    end
    idle(3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_vec++;
    if (underrun !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL clr_later got ur=%b or=%b want 0 0", underrun, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_prime_steady();
    test_underrun();
    test_overrun();
    test_full_push_pop();
    test_disable_reset();
    test_clr_status();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
